// File: rtl/fp_round_normalize_if.sv
// Bundle between the arithmetic cores, the normalize/round stage and the packer.
// Holds the input beat handshake, the result handshake and the sticky exception flags.
interface fp_round_normalize_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [12:0] in_exp;
  logic [55:0] in_mant;
  logic        in_sticky;
  logic        in_nan;
  logic        in_inf;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [10:0] out_exp_field;
  logic [51:0] out_mant_field;
  logic        out_is_nan;
  logic        out_is_inf;
  logic        out_is_zero;
  logic        flag_inexact;
  logic        flag_overflow;
  logic        flag_underflow;
  logic        flag_clr;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_nan, in_inf, in_zero,
    input  out_ready, flag_clr,
    output in_ready, out_valid, out_sign, out_exp_field, out_mant_field,
    output out_is_nan, out_is_inf, out_is_zero,
    output flag_inexact, flag_overflow, flag_underflow
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, in_nan, in_inf, in_zero,
    output out_ready, flag_clr,
    input  in_ready, out_valid, out_sign, out_exp_field, out_mant_field,
    input  out_is_nan, out_is_inf, out_is_zero,
    input  flag_inexact, flag_overflow, flag_underflow
  );
endinterface

// File: rtl/fp_round_normalize.sv
// Two-stage double-precision normalize (S1) and round-to-nearest-even/encode (S2).
// Define FP_EXC_FLAGS_EN to build the sticky inexact/overflow/underflow flags.
module fp_round_normalize (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_round_normalize_if.slave   io
);
  logic        adv;
  logic        out_valid_q;

  assign adv         = !out_valid_q || io.out_ready;
  assign io.in_ready = adv;

  // ---------------- S1: normalize ----------------
  logic [5:0]  lzc;
  logic [14:0] exp_ext, exp_n, sub_diff;
  logic [6:0]  sub_sh;
  logic [54:0] mant_n, lost_mask;
  logic        sticky_n, exact_zero;
  logic [54:0] s1_mant_d;
  logic [12:0] s1_exp_d;
  logic        s1_sticky_d, s1_tiny_d;

  always_comb begin
    lzc = 6'd55;
    for (int i = 0; i < 55; i++) begin
      if (io.in_mant[i]) lzc = 6'(54 - i);
    end
    exp_ext = {{2{io.in_exp[12]}}, io.in_exp};
    if (io.in_mant[55]) begin
      mant_n   = io.in_mant[55:1];
      sticky_n = io.in_sticky | io.in_mant[0];
      exp_n    = exp_ext + 15'd1;
    end else begin
      mant_n   = io.in_mant[54:0] << lzc;
      sticky_n = io.in_sticky;
      exp_n    = exp_ext - {9'd0, lzc};
    end
    // Exponent below 1 means a subnormal: denormalize and flag as tiny.
    s1_tiny_d = exp_n[14] || (exp_n == 15'd0);
    sub_diff  = 15'd1 - exp_n;
    sub_sh    = (sub_diff > 15'd56) ? 7'd56 : sub_diff[6:0];
    lost_mask = ~({55{1'b1}} << sub_sh);
    if (s1_tiny_d) begin
      s1_mant_d   = mant_n >> sub_sh;
      s1_sticky_d = sticky_n | (|(mant_n & lost_mask));
      s1_exp_d    = 13'd0;
    end else begin
      s1_mant_d   = mant_n;
      s1_sticky_d = sticky_n;
      s1_exp_d    = exp_n[12:0];
    end
    exact_zero = (io.in_mant == 56'd0) && !io.in_sticky;
  end

  logic        s1_valid_q, s1_sign_q, s1_sticky_q, s1_tiny_q;
  logic        s1_nan_q, s1_inf_q, s1_zero_q;
  logic [12:0] s1_exp_q;
  logic [54:0] s1_mant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_tiny_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
    end else if (adv) begin
      s1_valid_q  <= io.in_valid;
      s1_sign_q   <= io.in_sign;
      s1_sticky_q <= s1_sticky_d;
      s1_tiny_q   <= s1_tiny_d;
      s1_nan_q    <= io.in_nan;
      s1_inf_q    <= io.in_inf && !io.in_nan;
      s1_zero_q   <= (io.in_zero || exact_zero) && !io.in_nan && !io.in_inf;
      s1_exp_q    <= s1_exp_d;
      s1_mant_q   <= s1_mant_d;
    end
  end

  // ---------------- S2: round and encode ----------------
  logic        round_up, inexact_d, overflow_d, special, hidden;
  logic [53:0] rounded;
  logic [12:0] exp_r;
  logic [10:0] exp_field_d;
  logic [51:0] mant_field_d;
  logic        is_inf_d, is_zero_d, inx_set, ovf_set, unf_set;

  always_comb begin
    inexact_d = s1_mant_q[1] | s1_mant_q[0] | s1_sticky_q;
    round_up  = s1_mant_q[1] & (s1_mant_q[0] | s1_sticky_q | s1_mant_q[2]);
    rounded   = {1'b0, s1_mant_q[54:2]} + {53'd0, round_up};
    hidden    = rounded[53] | rounded[52];
    // A tiny value that rounds up into the hidden bit becomes the smallest normal.
    if (s1_tiny_q) exp_r = hidden ? 13'd1 : 13'd0;
    else           exp_r = s1_exp_q + {12'd0, rounded[53]};
    overflow_d = (exp_r >= 13'd2047);
    special    = s1_nan_q | s1_inf_q | s1_zero_q;

    exp_field_d  = 11'd0;
    mant_field_d = 52'd0;
    is_inf_d     = s1_inf_q;
    is_zero_d    = s1_zero_q;
    if (!special) begin
      if (overflow_d) begin
        is_inf_d = 1'b1;
      end else begin
        exp_field_d  = exp_r[10:0];
        mant_field_d = rounded[53] ? 52'd0 : rounded[51:0];
        is_zero_d    = s1_tiny_q && (rounded == 54'd0);
      end
    end
    inx_set = !special && inexact_d;
    ovf_set = !special && overflow_d;
    unf_set = !special && s1_tiny_q && inexact_d;
  end

  logic        out_sign_q, out_nan_q, out_inf_q, out_zero_q;
  logic [10:0] out_exp_q;
  logic [51:0] out_mant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_nan_q   <= 1'b0;
      out_inf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      out_exp_q   <= '0;
      out_mant_q  <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      out_sign_q  <= s1_sign_q;
      out_nan_q   <= s1_nan_q;
      out_inf_q   <= is_inf_d;
      out_zero_q  <= is_zero_d;
      out_exp_q   <= exp_field_d;
      out_mant_q  <= mant_field_d;
    end
  end

  assign io.out_valid      = out_valid_q;
  assign io.out_sign       = out_sign_q;
  assign io.out_exp_field  = out_exp_q;
  assign io.out_mant_field = out_mant_q;
  assign io.out_is_nan     = out_nan_q;
  assign io.out_is_inf     = out_inf_q;
  assign io.out_is_zero    = out_zero_q;

`ifdef FP_EXC_FLAGS_EN
  logic inx_q, ovf_q, unf_q;

  // Clear wins over a set landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inx_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (io.flag_clr) begin
      inx_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (adv && s1_valid_q) begin
      inx_q <= inx_q | inx_set;
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  assign io.flag_inexact   = inx_q;
  assign io.flag_overflow  = ovf_q;
  assign io.flag_underflow = unf_q;
`else
  logic unused_flags;
  assign unused_flags      = &{1'b0, io.flag_clr, inx_set, ovf_set, unf_set};
  assign io.flag_inexact   = 1'b0;
  assign io.flag_overflow  = 1'b0;
  assign io.flag_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fp_round_normalize.sv
// Scoreboard bench for fp_round_normalize: directed beats with hand-computed results,
// a monitor checking results, stall stability, in_ready and the sticky flag model.
module tb_fp_round_normalize;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_round_normalize_if io ();
  fp_round_normalize dut (.clk(clk), .rst_n(rst_n), .io(io.slave));

`ifdef FP_EXC_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  // res = {sign, exp_field[10:0], mant_field[51:0], nan, inf, zero}; exc = {inexact, overflow, underflow}
  typedef struct {
    string       name;
    logic        sign;
    logic [12:0] e;
    logic [55:0] m;
    logic        st;
    logic [2:0]  spec;
    logic [66:0] res;
    logic [2:0]  exc;
    bit          lat;
    int          acc_cyc;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[$];

  function automatic vec_t mkv(input string n, input logic s, input logic [12:0] e,
                               input logic [55:0] m, input logic st, input logic [2:0] spec,
                               input logic [66:0] res, input logic [2:0] exc);
    vec_t v;
    v.name = n; v.sign = s; v.e = e; v.m = m; v.st = st; v.spec = spec;
    v.res = res; v.exc = exc; v.lat = 1'b0; v.acc_cyc = 0;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Drive a beat (caller is just after a rising edge) and wait, bounded, for acceptance.
  task automatic send(input vec_t v);
    bit acc = 1'b0;
    int acc_c = 0;
    io.in_valid  = 1'b1;
    io.in_sign   = v.sign;
    io.in_exp    = v.e;
    io.in_mant   = v.m;
    io.in_sticky = v.st;
    {io.in_nan, io.in_inf, io.in_zero} = v.spec;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc   = io.in_ready && rst_n;
      acc_c = cyc;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      v.acc_cyc = acc_c;
      exp_q.push_back(v);
    end else begin
      total++;
      $display("FAIL accept_timeout %s: in_ready got 0 required 1", v.name);
    end
    io.in_valid = 1'b0;
  endtask

  // Monitor: pops expectations on each new result and tracks the sticky-flag model.
  initial begin : monitor
    bit          prev_adv = 1'b1;
    bit          prev_clr = 1'b0;
    bit          popped;
    logic [2:0]  fmodel = 3'b000;
    logic [66:0] cur, last = '0;
    vec_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_adv = 1'b1;
        prev_clr = 1'b0;
        fmodel   = 3'b000;
        check("reset_state", {io.out_valid, io.flag_inexact, io.flag_overflow, io.flag_underflow}, 0);
        continue;
      end
      cur = {io.out_sign, io.out_exp_field, io.out_mant_field, io.out_is_nan, io.out_is_inf, io.out_is_zero};
      popped = 1'b0;
      if (io.out_valid && prev_adv) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL spurious_beat: got result %0h required no beat", cur);
        end else begin
          e = exp_q.pop_front();
          popped = 1'b1;
          check(e.name, cur, e.res);
          if (e.lat) check("latency", cyc, e.acc_cyc + 2);
          $display("beat %-12s cyc %0d result %0h", e.name, cyc, cur);
        end
      end else if (io.out_valid) begin
        check("stall_hold", cur, last);
      end
      if (prev_clr) fmodel = 3'b000;
      else if (popped && FLAGS_EN) fmodel = fmodel | e.exc;
      check("flags", {io.flag_inexact, io.flag_overflow, io.flag_underflow}, fmodel);
      check("in_ready", io.in_ready, !io.out_valid || io.out_ready);
      last     = cur;
      prev_adv = !io.out_valid || io.out_ready;
      prev_clr = io.flag_clr;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    vec_t v_unit, v_carry, v_ovf, v_sub, v_canc, v_tieodd, v_sticky;
    io.in_valid = 1'b0; io.in_sign = 1'b0; io.in_exp = '0; io.in_mant = '0;
    io.in_sticky = 1'b0; io.in_nan = 1'b0; io.in_inf = 1'b0; io.in_zero = 1'b0;
    io.out_ready = 1'b1; io.flag_clr = 1'b0;

    v_unit   = mkv("unit", 1'b0, 13'd1023, 56'h40_0000_0000_0000, 1'b0, 3'b000,
                   {1'b0, 11'h3FF, 52'h0, 3'b000}, 3'b000);
    v_carry  = mkv("round_carry", 1'b0, 13'd1023, 56'h7F_FFFF_FFFF_FFFF, 1'b0, 3'b000,
                   {1'b0, 11'h400, 52'h0, 3'b000}, 3'b100);
    v_ovf    = mkv("overflow", 1'b1, 13'd2046, 56'h7F_FFFF_FFFF_FFFF, 1'b0, 3'b000,
                   {1'b1, 11'h0, 52'h0, 3'b010}, 3'b110);
    v_sub    = mkv("subnormal", 1'b0, 13'd0, 56'h40_0000_0000_0000, 1'b0, 3'b000,
                   {1'b0, 11'h0, 52'h8_0000_0000_0000, 3'b000}, 3'b000);
    v_canc   = mkv("cancel", 1'b0, 13'd1023, 56'h400, 1'b0, 3'b000,
                   {1'b0, 11'h3D3, 52'h0, 3'b000}, 3'b000);
    v_tieodd = mkv("tie_odd", 1'b0, 13'd1023, 56'h40_0000_0000_0006, 1'b0, 3'b000,
                   {1'b0, 11'h3FF, 52'h2, 3'b000}, 3'b100);
    v_sticky = mkv("sticky_only", 1'b1, 13'd1023, 56'h40_0000_0000_0000, 1'b1, 3'b000,
                   {1'b1, 11'h3FF, 52'h0, 3'b000}, 3'b100);
    v_unit.lat = 1'b1;

    vecs.push_back(v_unit);
    vecs.push_back(v_carry);
    vecs.push_back(v_ovf);
    vecs.push_back(v_sub);
    vecs.push_back(v_canc);
    vecs.push_back(mkv("carry_pos", 1'b0, 13'd1023, 56'h80_0000_0000_0000, 1'b0, 3'b000,
                       {1'b0, 11'h400, 52'h0, 3'b000}, 3'b000));
    vecs.push_back(mkv("tie_even", 1'b0, 13'd1023, 56'h40_0000_0000_0002, 1'b0, 3'b000,
                       {1'b0, 11'h3FF, 52'h0, 3'b000}, 3'b100));
    vecs.push_back(v_tieodd);
    vecs.push_back(v_sticky);
    vecs.push_back(mkv("exact_zero", 1'b1, 13'd500, 56'h0, 1'b0, 3'b000,
                       {1'b1, 11'h0, 52'h0, 3'b001}, 3'b000));
    vecs.push_back(mkv("nan_inf", 1'b0, 13'd1023, 56'h7F_FFFF_FFFF_FFFF, 1'b1, 3'b110,
                       {1'b0, 11'h0, 52'h0, 3'b100}, 3'b000));
    vecs.push_back(mkv("inf", 1'b1, 13'd5, 56'h3, 1'b0, 3'b010,
                       {1'b1, 11'h0, 52'h0, 3'b010}, 3'b000));
    vecs.push_back(mkv("zero_flag", 1'b0, 13'd1023, 56'h40_0000_0000_0001, 1'b1, 3'b001,
                       {1'b0, 11'h0, 52'h0, 3'b001}, 3'b000));
    vecs.push_back(mkv("sub_to_zero", 1'b1, 13'h1FC4, 56'h40_0000_0000_0000, 1'b0, 3'b000,
                       {1'b1, 11'h0, 52'h0, 3'b001}, 3'b101));
    vecs.push_back(mkv("tiny_to_norm", 1'b0, 13'd0, 56'h7F_FFFF_FFFF_FFFF, 1'b0, 3'b000,
                       {1'b0, 11'h001, 52'h0, 3'b000}, 3'b101));
    vecs.push_back(mkv("sub_exact", 1'b0, 13'h1FFF, 56'h40_0000_0000_0000, 1'b0, 3'b000,
                       {1'b0, 11'h0, 52'h4_0000_0000_0000, 3'b000}, 3'b000));
    vecs.push_back(mkv("exp_ovf", 1'b0, 13'd2047, 56'h40_0000_0000_0000, 1'b0, 3'b000,
                       {1'b0, 11'h0, 52'h0, 3'b010}, 3'b010));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unit value alone so its latency is measured with an empty pipeline.
    send(vecs[0]);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 1; i < vecs.size(); i++) send(vecs[i]);

    // Backpressure: four beats streamed while the consumer stalls for three cycles.
    fork
      begin
        send(v_canc);
        send(v_tieodd);
        send(v_sub);
        send(v_carry);
      end
      begin
        repeat (2) @(posedge clk);
        #1 io.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 io.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Flag clear on the same edge the inexact beat reaches the output stage.
    send(v_sticky);
    io.flag_clr = 1'b1;
    @(posedge clk);
    #1 io.flag_clr = 1'b0;
    send(v_tieodd);
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset with beats in flight.
    send(v_carry);
    send(v_unit);
    send(v_sub);
    rst_n = 1'b0;
    #1;
    check("reset_async", {io.out_valid, io.flag_inexact, io.flag_overflow, io.flag_underflow}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(v_canc);

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
